pipeline_control: RTL and testbench
===================================

# pipeline_control

Pipeline sequencing controller for the five-stage processor. Each cycle it decides which pipeline registers advance, stall, flush or take a bubble, covering load-use and branch-operand hazards, taken-branch squash, multicycle memory freezes and the HLT drain sequence. It sits beside the hazard/forwarding logic and drives the PC and the F/D, D/X, X/M and M/W register write enables. It also keeps a saturating hazard-stall counter for performance inspection.

## Interface
Parameters
- DRAIN_CYCLES, 3: cycles from HLT leaving decode to HLT completing writeback.
- CNT_W, 16: width of the stall counter.

Ports
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- mem_busy  in  1  memory stage has a multicycle access outstanding.
- rs_fd, rt_fd  in  4  source register IDs of the instruction in decode.
- uses_rs_fd, uses_rt_fd  in  1  decode instruction reads rs / rt.
- is_branch_fd  in  1  decode instruction is B or BR.
- is_br_reg_fd  in  1  decode instruction is BR (target taken from rs).
- branch_taken_fd  in  1  branch in decode resolved taken.
- halt_fd  in  1  decode instruction is HLT.
- mem_read_de, reg_write_de, flag_write_de  in  1  execute-stage instruction is a load / writes a register / updates flags.
- rd_de  in  4  execute-stage destination register.
- mem_read_xm  in  1  memory-stage instruction is a load.
- rd_xm  in  4  memory-stage destination register.
- pc_we, fd_we, de_we, xm_we, mw_we  out  1  write enables for the PC and the pipeline registers.
- fd_flush  out  1  load a NOP into F/D.
- de_bubble  out  1  load a NOP into D/X.
- halted  out  1  processor halted.
- stall_count  out  CNT_W  number of hazard-stall cycles, saturating.

## Operation
- FSM states:
  - RUN: normal operation.
  - DRAIN: HLT in flight; count down DRAIN_CYCLES.
  - HALTED: terminal until reset.
- Register R0 never causes a hazard (rd==0 is ignored).
- Control outputs are combinational from the current state and inputs. Evaluate the rules below in priority order; the first match wins.
  1. rst=1: all enables 0, fd_flush=0, de_bubble=0. Next state RUN, drain counter 0, stall_count 0.
  2. HALTED: all enables 0, halted=1.
  3. mem_busy=1: all enables 0, no flush or bubble. FSM and drain counter hold.
  4. Load-use hazard: mem_read_de and rd_de matches a used source in decode. Then pc_we=0, fd_we=0, de_bubble=1; xm_we and mw_we are 1.
  5. Branch hazard, with the same response as rule 4. Any of:
     - is_branch_fd and flag_write_de;
     - is_br_reg_fd, reg_write_de, rd_de==rs_fd;
     - is_br_reg_fd, mem_read_xm, rd_xm==rs_fd.
  6. State RUN and branch_taken_fd: all enables 1 and fd_flush=1, which squashes the sequential fetch.
  7. State RUN and halt_fd: pc_we=0, fd_flush=1, other enables 1. Next state DRAIN with counter=DRAIN_CYCLES-1.
  8. DRAIN: pc_we=0, fd_flush=1, other enables 1, counter decrements. When the counter is 0, next state is HALTED.
  9. Otherwise: all enables 1, no flush or bubble.
- While in DRAIN, hazard rules 4 and 5 still apply; halt_fd is ignored.
- stall_count increments on every cycle where rule 4 or 5 fires. It saturates at all-ones and does not count cycles frozen by mem_busy.

## Timing
- Reset state: RUN, counter 0, stall_count 0, halted 0. The first cycle after reset shows all enables 1 when no hazard is present.
- A load-use stall costs exactly one bubble. Rule 4 stops firing once the load advances to X/M.
- A BR dependency on a load stalls two cycles: the first via rule 4 or 5 on rd_de, the second via rule 5 on rd_xm.
- A taken branch costs one flushed slot and no stall.
- halted rises DRAIN_CYCLES+1 non-frozen cycles after the cycle in which HLT is seen in decode.
- mem_busy lasting N cycles extends any sequence by exactly N cycles with no state change.
- When mem_busy and a hazard occur together, the freeze wins and the hazard is re-evaluated once mem_busy clears.
- rst asserted during DRAIN or HALTED returns to RUN on the next edge.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum {RUN, DRAIN, HALTED};
  - DRAIN_CYCLES;
  - the 4-bit opcode constants B, BR, HLT;
  - the register-zero constant.
- Sub-module hazard_detect: purely combinational. Outputs load_use and branch_hazard from the register-ID compares.
- The top level holds the FSM, the drain counter, the stall counter and the priority mux.

## Test plan
- Load-use: mem_read_de=1, rd_de=3, rs_fd=3, uses_rs_fd=1 for one cycle -> pc_we=0, fd_we=0, de_bubble=1, stall_count=1. Next cycle with rd_de cleared -> all enables 1.
- R0 immunity: mem_read_de=1, rd_de=0, rs_fd=0, uses_rs_fd=1 -> no stall, stall_count stays 0.
- BR behind load: is_br_reg_fd=1, rs_fd=5. Load with rd=5 in X, then in M -> two stall cycles, stall_count=2. Then branch_taken_fd=1 -> fd_flush=1, pc_we=1.
- Halt drain: halt_fd=1 in RUN -> pc_we=0, fd_flush=1 for 4 cycles. halted=1 on cycle 4 and stays until rst, with all enables 0.
- Freeze: mem_busy=1 for 5 cycles, asserted during DRAIN with counter=1 -> all enables 0, counter held. halted rises 2 cycles after mem_busy drops.
- Saturation/reset: force 65537 load-use cycles -> stall_count=16'hFFFF. Assert rst for one cycle -> stall_count=0, state RUN, halted=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Imported by hazard_detect and pipeline_control.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int DRAIN_CYCLES = 3;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] REG_ZERO = 4'd0;

    function automatic logic is_zero_reg(input logic [3:0] r);
        return r == REG_ZERO;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational register-ID compares for load-use and branch-operand hazards.
// R0 is hardwired, so a zero destination never raises a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       mem_read_de,
    input  logic       reg_write_de,
    input  logic       flag_write_de,
    input  logic [3:0] rd_de,
    input  logic       mem_read_xm,
    input  logic [3:0] rd_xm,
    input  logic [3:0] rs_fd,
    input  logic [3:0] rt_fd,
    input  logic       uses_rs_fd,
    input  logic       uses_rt_fd,
    input  logic       is_branch_fd,
    input  logic       is_br_reg_fd,
    output logic       load_use,
    output logic       branch_hazard
);

    logic de_live;
    logic xm_live;
    logic rs_hit_de;
    logic rt_hit_de;
    logic rs_hit_xm;

    assign de_live   = !is_zero_reg(rd_de);
    assign xm_live   = !is_zero_reg(rd_xm);
    assign rs_hit_de = de_live && (rd_de == rs_fd);
    assign rt_hit_de = de_live && (rd_de == rt_fd);
    assign rs_hit_xm = xm_live && (rd_xm == rs_fd);

    assign load_use = mem_read_de &&
                      ((uses_rs_fd && rs_hit_de) ||
                       (uses_rt_fd && rt_hit_de));

    // BR reads its target from rs in decode, so it cannot use forwarding
    assign branch_hazard = (is_branch_fd && flag_write_de) ||
                           (is_br_reg_fd && reg_write_de && rs_hit_de) ||
                           (is_br_reg_fd && mem_read_xm && rs_hit_xm);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline sequencing: stall, flush, bubble, memory freeze and HLT drain.
// Also keeps a saturating count of hazard-stall cycles.
module pipeline_control #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_busy,
    input  logic [3:0]       rs_fd,
    input  logic [3:0]       rt_fd,
    input  logic             uses_rs_fd,
    input  logic             uses_rt_fd,
    input  logic             is_branch_fd,
    input  logic             is_br_reg_fd,
    input  logic             branch_taken_fd,
    input  logic             halt_fd,
    input  logic             mem_read_de,
    input  logic             reg_write_de,
    input  logic             flag_write_de,
    input  logic [3:0]       rd_de,
    input  logic             mem_read_xm,
    input  logic [3:0]       rd_xm,
    output logic             pc_we,
    output logic             fd_we,
    output logic             de_we,
    output logic             xm_we,
    output logic             mw_we,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    import pipe_ctrl_pkg::*;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    logic            load_use;
    logic            branch_hazard;
    logic            stall_hit;
    logic            halt_start;
    logic            drain_step;

    hazard_detect u_hazard (
        .mem_read_de   (mem_read_de),
        .reg_write_de  (reg_write_de),
        .flag_write_de (flag_write_de),
        .rd_de         (rd_de),
        .mem_read_xm   (mem_read_xm),
        .rd_xm         (rd_xm),
        .rs_fd         (rs_fd),
        .rt_fd         (rt_fd),
        .uses_rs_fd    (uses_rs_fd),
        .uses_rt_fd    (uses_rt_fd),
        .is_branch_fd  (is_branch_fd),
        .is_br_reg_fd  (is_br_reg_fd),
        .load_use      (load_use),
        .branch_hazard (branch_hazard)
    );

    always_comb begin
        pc_we      = 1'b0;
        fd_we      = 1'b0;
        de_we      = 1'b0;
        xm_we      = 1'b0;
        mw_we      = 1'b0;
        fd_flush   = 1'b0;
        de_bubble  = 1'b0;
        stall_hit  = 1'b0;
        halt_start = 1'b0;
        drain_step = 1'b0;
        if (rst || state == HALTED || mem_busy) begin
            // everything frozen
        end else if (load_use || branch_hazard) begin
            de_we     = 1'b1;
            xm_we     = 1'b1;
            mw_we     = 1'b1;
            de_bubble = 1'b1;
            stall_hit = 1'b1;
        end else if (state == RUN && branch_taken_fd) begin
            pc_we    = 1'b1;
            fd_we    = 1'b1;
            de_we    = 1'b1;
            xm_we    = 1'b1;
            mw_we    = 1'b1;
            fd_flush = 1'b1;
        end else if (state == RUN && halt_fd) begin
            fd_we      = 1'b1;
            de_we      = 1'b1;
            xm_we      = 1'b1;
            mw_we      = 1'b1;
            fd_flush   = 1'b1;
            halt_start = 1'b1;
        end else if (state == DRAIN) begin
            fd_we      = 1'b1;
            de_we      = 1'b1;
            xm_we      = 1'b1;
            mw_we      = 1'b1;
            fd_flush   = 1'b1;
            drain_step = 1'b1;
        end else begin
            pc_we = 1'b1;
            fd_we = 1'b1;
            de_we = 1'b1;
            xm_we = 1'b1;
            mw_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            stall_count <= '0;
        end else begin
            if (halt_start) begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_LOAD;
            end else if (drain_step) begin
                if (drain_cnt == '0) begin
                    state <= HALTED;
                end else begin
                    drain_cnt <= drain_cnt - 1'b1;
                end
            end
            if (stall_hit && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control with hand-computed expectations.
// Covers hazards, R0, branches, HLT drain, freeze, saturation and reset.
module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_busy;
    logic [3:0]  rs_fd, rt_fd;
    logic        uses_rs_fd, uses_rt_fd;
    logic        is_branch_fd, is_br_reg_fd;
    logic        branch_taken_fd, halt_fd;
    logic        mem_read_de, reg_write_de, flag_write_de;
    logic [3:0]  rd_de;
    logic        mem_read_xm;
    logic [3:0]  rd_xm;
    logic        pc_we, fd_we, de_we, xm_we, mw_we;
    logic        fd_flush, de_bubble, halted;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_control #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_busy        (mem_busy),
        .rs_fd           (rs_fd),
        .rt_fd           (rt_fd),
        .uses_rs_fd      (uses_rs_fd),
        .uses_rt_fd      (uses_rt_fd),
        .is_branch_fd    (is_branch_fd),
        .is_br_reg_fd    (is_br_reg_fd),
        .branch_taken_fd (branch_taken_fd),
        .halt_fd         (halt_fd),
        .mem_read_de     (mem_read_de),
        .reg_write_de    (reg_write_de),
        .flag_write_de   (flag_write_de),
        .rd_de           (rd_de),
        .mem_read_xm     (mem_read_xm),
        .rd_xm           (rd_xm),
        .pc_we           (pc_we),
        .fd_we           (fd_we),
        .de_we           (de_we),
        .xm_we           (xm_we),
        .mw_we           (mw_we),
        .fd_flush        (fd_flush),
        .de_bubble       (de_bubble),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pc,fd,de,xm,mw,flush,bubble}
    function automatic logic [6:0] ctl();
        return {pc_we, fd_we, de_we, xm_we, mw_we, fd_flush, de_bubble};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_busy = 0; rs_fd = 0; rt_fd = 0;
        uses_rs_fd = 0; uses_rt_fd = 0;
        is_branch_fd = 0; is_br_reg_fd = 0;
        branch_taken_fd = 0; halt_fd = 0;
        mem_read_de = 0; reg_write_de = 0; flag_write_de = 0; rd_de = 0;
        mem_read_xm = 0; rd_xm = 0;
    endtask

    localparam logic [6:0] ALL_ON = 7'b1111100;
    localparam logic [6:0] FROZEN = 7'b0000000;
    localparam logic [6:0] STALL  = 7'b0011101;
    localparam logic [6:0] SQUASH = 7'b1111110;
    localparam logic [6:0] DRAINC = 7'b0111110;

    initial begin
        int exp_stall;
        exp_stall = 0;
        idle();
        rst = 1;
        #1;
        check("rst_ctl", 32'(ctl()), 32'(FROZEN));
        cyc();
        rst = 0;
        #1;
        check("reset_ctl", 32'(ctl()), 32'(ALL_ON));
        check("reset_halted", 32'(halted), 0);
        check("reset_stall", 32'(stall_count), 0);

        // load-use on rs
        mem_read_de = 1; rd_de = 3; rs_fd = 3; uses_rs_fd = 1;
        #1 check("lu_ctl", 32'(ctl()), 32'(STALL));
        cyc(); exp_stall++;
        check("lu_cnt", 32'(stall_count), 32'(exp_stall));
        rd_de = 0; mem_read_de = 0;
        #1 check("lu_clear", 32'(ctl()), 32'(ALL_ON));

        // R0 immunity
        idle();
        mem_read_de = 1; rd_de = 0; rs_fd = 0; uses_rs_fd = 1;
        #1 check("r0_ctl", 32'(ctl()), 32'(ALL_ON));
        cyc();
        check("r0_cnt", 32'(stall_count), 32'(exp_stall));

        // load-use on rt only
        idle();
        mem_read_de = 1; rd_de = 7; rt_fd = 7; uses_rt_fd = 1; rs_fd = 7;
        #1 check("lu_rt", 32'(ctl()), 32'(STALL));
        uses_rt_fd = 0;
        #1 check("lu_rt_unused", 32'(ctl()), 32'(ALL_ON));
        uses_rt_fd = 1;
        cyc(); exp_stall++;

        // BR behind load: X then M
        idle();
        is_br_reg_fd = 1; is_branch_fd = 1; rs_fd = 5;
        mem_read_de = 1; reg_write_de = 1; rd_de = 5;
        #1 check("br_x", 32'(ctl()), 32'(STALL));
        cyc(); exp_stall++;
        mem_read_de = 0; reg_write_de = 0; rd_de = 0;
        mem_read_xm = 1; rd_xm = 5;
        #1 check("br_m", 32'(ctl()), 32'(STALL));
        cyc(); exp_stall++;
        check("br_cnt", 32'(stall_count), 32'(exp_stall));
        mem_read_xm = 0; rd_xm = 0; branch_taken_fd = 1;
        #1 check("br_taken", 32'(ctl()), 32'(SQUASH));
        cyc();

        // BR on ALU result in X (no load)
        idle();
        is_br_reg_fd = 1; is_branch_fd = 1; rs_fd = 9;
        reg_write_de = 1; rd_de = 9;
        #1 check("br_alu", 32'(ctl()), 32'(STALL));
        cyc(); exp_stall++;

        // flag hazard on B
        idle();
        is_branch_fd = 1; flag_write_de = 1;
        #1 check("flag_hz", 32'(ctl()), 32'(STALL));
        cyc(); exp_stall++;

        // freeze beats hazard, hazard re-evaluated afterwards
        idle();
        mem_read_de = 1; rd_de = 2; rs_fd = 2; uses_rs_fd = 1; mem_busy = 1;
        #1 check("frz_hz_ctl", 32'(ctl()), 32'(FROZEN));
        cyc();
        check("frz_hz_cnt", 32'(stall_count), 32'(exp_stall));
        mem_busy = 0;
        #1 check("post_frz_hz", 32'(ctl()), 32'(STALL));
        cyc(); exp_stall++;
        check("post_frz_cnt", 32'(stall_count), 32'(exp_stall));

        // HLT drain with a freeze while counter=1
        idle();
        halt_fd = 1;
        #1 check("hlt_c0", 32'(ctl()), 32'(DRAINC));
        cyc();
        #1 check("hlt_c1", 32'(ctl()), 32'(DRAINC));
        cyc();
        mem_busy = 1;
        for (int i = 0; i < 5; i++) begin
            #1 check("drn_frz", 32'(ctl()), 32'(FROZEN));
            cyc();
        end
        mem_busy = 0;
        #1 check("hlt_c2", 32'(ctl()), 32'(DRAINC));
        cyc();
        #1 check("hlt_c3", 32'(ctl()), 32'(DRAINC));
        check("hlt_c3_halted", 32'(halted), 0);
        cyc();
        check("halted", 32'(halted), 1);
        check("halted_ctl", 32'(ctl()), 32'(FROZEN));
        halt_fd = 0;
        mem_read_de = 1; rd_de = 4; rs_fd = 4; uses_rs_fd = 1;
        repeat (3) cyc();
        check("halted_hold", 32'(halted), 1);
        check("halted_nocnt", 32'(stall_count), 32'(exp_stall));

        // reset out of HALTED
        idle();
        rst = 1;
        cyc();
        rst = 0;
        #1 check("rst_halted", 32'(halted), 0);
        check("rst_cnt", 32'(stall_count), 0);
        check("rst_run", 32'(ctl()), 32'(ALL_ON));

        // reset during DRAIN
        halt_fd = 1;
        cyc();
        halt_fd = 0;
        rst = 1;
        cyc();
        rst = 0;
        repeat (4) cyc();
        check("rst_drain_halted", 32'(halted), 0);
        check("rst_drain_ctl", 32'(ctl()), 32'(ALL_ON));

        // saturation
        mem_read_de = 1; rd_de = 6; rs_fd = 6; uses_rs_fd = 1;
        repeat (65537) cyc();
        check("sat_cnt", 32'(stall_count), 32'h0000_FFFF);
        idle();
        rst = 1;
        cyc();
        rst = 0;
        #1 check("sat_rst_cnt", 32'(stall_count), 0);
        check("sat_rst_halted", 32'(halted), 0);
        check("sat_rst_ctl", 32'(ctl()), 32'(ALL_ON));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
